// File: rtl/wb_arb_mux.sv
`default_nettype none
// ============================================================================
// wb_arb_mux : N-master to 1-slave Wishbone B3 arbiter/multiplexer with
//              bus parking and a response watchdog.
// Revision   : 1.0
// ============================================================================
module wb_arb_mux #(
  parameter  int MASTERS    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int ARB_MODE   = 0,
  parameter  int TIMEOUT    = 256,
  localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,

  input  logic [ADDR_WIDTH*MASTERS-1:0] m_adr_i,
  input  logic [DATA_WIDTH*MASTERS-1:0] m_dat_i,
  input  logic [SEL_WIDTH*MASTERS-1:0]  m_sel_i,
  input  logic [MASTERS-1:0]            m_cyc_i,
  input  logic [MASTERS-1:0]            m_stb_i,
  input  logic [MASTERS-1:0]            m_we_i,
  input  logic [3*MASTERS-1:0]          m_cti_i,
  input  logic [2*MASTERS-1:0]          m_bte_i,
  output logic [DATA_WIDTH*MASTERS-1:0] m_dat_o,
  output logic [MASTERS-1:0]            m_ack_o,
  output logic [MASTERS-1:0]            m_err_o,
  output logic [MASTERS-1:0]            m_rty_o,

  output logic [ADDR_WIDTH-1:0]         s_adr_o,
  output logic [DATA_WIDTH-1:0]         s_dat_o,
  output logic [SEL_WIDTH-1:0]          s_sel_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  input  logic [DATA_WIDTH-1:0]         s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,

  input  logic                          bus_hold,
  output logic                          bus_hold_ack
);

  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int REQ_W = ADDR_WIDTH + DATA_WIDTH + SEL_WIDTH + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_ack_q, hold_ack_d;

  logic                           cur_cyc;
  logic                           arb_pt;
  logic                           resp;
  logic                           timeout_hit;
  logic                           stb_sel;
  logic [MASTERS-1:0][REQ_W-1:0]  req_pack;
  logic [REQ_W-1:0]               req_mux;
  logic [MASTERS-1:0]             higher;
  logic [MASTERS-1:0]             pool;
  logic [MASTERS-1:0]             win;
  logic [IDX_W-1:0]               win_idx;
  logic [IDX_W-1:0][MASTERS-1:0]  idx_terms;

  // Each master's request fields packed into one word, then AND-OR muxed
  // bit by bit against the one-hot grant so an empty grant yields zeros.
  for (genvar j = 0; j < MASTERS; j++) begin : g_pack
    assign req_pack[j] = {m_adr_i[j*ADDR_WIDTH +: ADDR_WIDTH],
                          m_dat_i[j*DATA_WIDTH +: DATA_WIDTH],
                          m_sel_i[j*SEL_WIDTH +: SEL_WIDTH],
                          m_we_i[j], m_stb_i[j],
                          m_cti_i[j*3 +: 3], m_bte_i[j*2 +: 2]};
  end

  for (genvar k = 0; k < REQ_W; k++) begin : g_col
    logic [MASTERS-1:0] col;
    for (genvar j = 0; j < MASTERS; j++) begin : g_bit
      assign col[j] = req_pack[j][k];
    end
    assign req_mux[k] = |(col & gnt_q);
  end

  assign {s_adr_o, s_dat_o, s_sel_o, s_we_o, stb_sel, s_cti_o, s_bte_o} = req_mux;

  assign cur_cyc = |(gnt_q & m_cyc_i);
  assign s_cyc_o = cur_cyc;
  assign s_stb_o = stb_sel & ~timeout_hit;

  // Round-robin favours requesters above the previous winner, else wraps.
  for (genvar j = 0; j < MASTERS; j++) begin : g_higher
    assign higher[j] = (IDX_W'(j) > last_q);
  end

  assign pool = (ARB_MODE == 0 && |(m_cyc_i & higher)) ? (m_cyc_i & higher) : m_cyc_i;
  assign win  = pool & (~pool + MASTERS'(1));

  for (genvar b = 0; b < IDX_W; b++) begin : g_enc
    for (genvar j = 0; j < MASTERS; j++) begin : g_term
      if (((j >> b) & 1) == 1) begin : g_on
        assign idx_terms[b][j] = win[j];
      end else begin : g_off
        assign idx_terms[b][j] = 1'b0;
      end
    end
    assign win_idx[b] = |idx_terms[b];
  end

  assign arb_pt = (state_q == ST_IDLE) || (state_q == ST_GRANTED && !cur_cyc);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    hold_ack_d = hold_ack_q;
    if (state_q == ST_HOLD) begin
      if (!bus_hold) begin
        state_d    = ST_IDLE;
        hold_ack_d = 1'b0;
      end
    end else if (arb_pt) begin
      if (bus_hold) begin
        state_d    = ST_HOLD;
        gnt_d      = '0;
        hold_ack_d = 1'b1;
      end else if (|m_cyc_i) begin
        state_d = ST_GRANTED;
        gnt_d   = win;
        last_d  = win_idx;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    end
  end

  // A real slave response in the final watchdog cycle beats the timeout.
  assign resp        = s_ack_i | s_err_i | s_rty_i;
  assign timeout_hit = (TIMEOUT > 0) && (state_q == ST_GRANTED) && stb_sel && !resp
                       && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (TIMEOUT == 0 || state_q != ST_GRANTED || !stb_sel || resp || timeout_hit
        || gnt_d != gnt_q) begin
      cnt_d = '0;
    end
  end

  assign m_dat_o      = {MASTERS{s_dat_i}};
  assign m_ack_o      = gnt_q & {MASTERS{s_ack_i & ~timeout_hit}};
  assign m_err_o      = gnt_q & {MASTERS{s_err_i | timeout_hit}};
  assign m_rty_o      = gnt_q & {MASTERS{s_rty_i & ~timeout_hit}};
  assign bus_hold_ack = hold_ack_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      last_q     <= IDX_W'(MASTERS - 1);
      cnt_q      <= '0;
      hold_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      hold_ack_q <= hold_ack_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arb_mux.sv
`default_nettype none
// ============================================================================
// tb_wb_arb_mux : directed bench for wb_arb_mux, one round-robin and one
//                 fixed-priority instance driven from shared stimulus.
// Revision      : 1.0
// ============================================================================
module tb_wb_arb_mux;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [127:0] m_adr_i;
  logic [127:0] m_dat_i;
  logic [15:0]  m_sel_i;
  logic [3:0]   m_cyc_i, m_stb_i, m_we_i;
  logic [11:0]  m_cti_i;
  logic [7:0]   m_bte_i;
  logic [31:0]  s_dat_i;
  logic         s_ack_i, s_err_i, s_rty_i;
  logic         bus_hold;

  logic [127:0] rr_m_dat_o, fp_m_dat_o;
  logic [3:0]   rr_m_ack_o, rr_m_err_o, rr_m_rty_o;
  logic [3:0]   fp_m_ack_o, fp_m_err_o, fp_m_rty_o;
  logic [31:0]  rr_s_adr_o, rr_s_dat_o, fp_s_adr_o, fp_s_dat_o;
  logic [3:0]   rr_s_sel_o, fp_s_sel_o;
  logic         rr_s_cyc_o, rr_s_stb_o, rr_s_we_o, fp_s_cyc_o, fp_s_stb_o, fp_s_we_o;
  logic [2:0]   rr_s_cti_o, fp_s_cti_o;
  logic [1:0]   rr_s_bte_o, fp_s_bte_o;
  logic         rr_bus_hold_ack, fp_bus_hold_ack;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  wb_arb_mux #(.MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(0), .TIMEOUT(4)) dut_rr (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(rr_m_dat_o), .m_ack_o(rr_m_ack_o), .m_err_o(rr_m_err_o), .m_rty_o(rr_m_rty_o),
    .s_adr_o(rr_s_adr_o), .s_dat_o(rr_s_dat_o), .s_sel_o(rr_s_sel_o),
    .s_cyc_o(rr_s_cyc_o), .s_stb_o(rr_s_stb_o), .s_we_o(rr_s_we_o),
    .s_cti_o(rr_s_cti_o), .s_bte_o(rr_s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .bus_hold(bus_hold), .bus_hold_ack(rr_bus_hold_ack)
  );

  wb_arb_mux #(.MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(1), .TIMEOUT(4)) dut_fp (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(fp_m_dat_o), .m_ack_o(fp_m_ack_o), .m_err_o(fp_m_err_o), .m_rty_o(fp_m_rty_o),
    .s_adr_o(fp_s_adr_o), .s_dat_o(fp_s_dat_o), .s_sel_o(fp_s_sel_o),
    .s_cyc_o(fp_s_cyc_o), .s_stb_o(fp_s_stb_o), .s_we_o(fp_s_we_o),
    .s_cti_o(fp_s_cti_o), .s_bte_o(fp_s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .bus_hold(bus_hold), .bus_hold_ack(fp_bus_hold_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni   = 1'b0;
    m_adr_i  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    m_dat_i  = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    m_sel_i  = {4'h8, 4'h4, 4'h2, 4'h1};
    m_we_i   = 4'b1010;
    m_cti_i  = {3'd7, 3'd2, 3'd1, 3'd0};
    m_bte_i  = {2'd3, 2'd2, 2'd1, 2'd0};
    m_cyc_i  = 4'b0001;
    m_stb_i  = 4'b0001;
    s_dat_i  = 32'h5A5A_1234;
    s_ack_i  = 1'b0;
    s_err_i  = 1'b0;
    s_rty_i  = 1'b0;
    bus_hold = 1'b0;

    // Reset state: requests ignored, all slave outputs zero.
    step;
    step;
    check("rst_s_cyc", 64'(rr_s_cyc_o), 64'h0);
    check("rst_s_stb", 64'(rr_s_stb_o), 64'h0);
    check("rst_s_adr", 64'(rr_s_adr_o), 64'h0);
    check("rst_hold_ack", 64'(rr_bus_hold_ack), 64'h0);
    s_ack_i = 1'b1;
    #1;
    check("rst_m_ack", 64'(rr_m_ack_o), 64'h0);
    s_ack_i = 1'b0;
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    rst_ni  = 1'b1;
    step;

    // Round-robin between masters 0 and 2.
    m_cyc_i = 4'b0101;
    m_stb_i = 4'b0101;
    #1;
    check("rr_latency", 64'(rr_s_cyc_o), 64'h0);
    step;
    check("rr_g0_adr", 64'(rr_s_adr_o), 64'hA000_0000);
    check("rr_g0_cyc", 64'(rr_s_cyc_o), 64'h1);
    s_ack_i = 1'b1;
    #1;
    check("rr_g0_ack", 64'(rr_m_ack_o), 64'h1);
    check("rr_dat_bcast", 64'(rr_m_dat_o[127:96]), 64'h5A5A_1234);
    step;
    m_cyc_i = 4'b0100;
    m_stb_i = 4'b0100;
    s_ack_i = 1'b0;
    #1;
    check("rr_release_cyc", 64'(rr_s_cyc_o), 64'h0);
    step;
    check("rr_g2_adr", 64'(rr_s_adr_o), 64'hA000_0002);
    m_cyc_i = 4'b0101;
    m_stb_i = 4'b0101;
    s_ack_i = 1'b1;
    #1;
    check("rr_g2_ack", 64'(rr_m_ack_o), 64'h4);
    step;
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    s_ack_i = 1'b0;
    step;
    check("rr_g0b_adr", 64'(rr_s_adr_o), 64'hA000_0000);
    s_ack_i = 1'b1;
    #1;
    check("rr_g0b_ack", 64'(rr_m_ack_o), 64'h1);
    step;
    m_cyc_i = 4'b0100;
    m_stb_i = 4'b0100;
    s_ack_i = 1'b0;
    step;
    check("rr_g2b_adr", 64'(rr_s_adr_o), 64'hA000_0002);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    step;
    step;

    // Masters 1 and 3 with single-cycle transactions: fixed priority vs round-robin.
    m_cyc_i = 4'b1010;
    m_stb_i = 4'b1010;
    s_ack_i = 1'b1;
    step;
    check("fp_g1_adr", 64'(fp_s_adr_o), 64'hA000_0001);
    check("fp_g1_ack", 64'(fp_m_ack_o), 64'h2);
    check("fp_g1_fields", 64'({fp_s_dat_o, fp_s_sel_o, fp_s_we_o, fp_s_cti_o, fp_s_bte_o}),
          64'({32'hD000_0001, 4'h2, 1'b1, 3'd1, 2'd1}));
    check("rr_g3_adr", 64'(rr_s_adr_o), 64'hA000_0003);
    check("rr_g3_ack", 64'(rr_m_ack_o), 64'h8);
    step;
    step;
    check("fp_g1_held", 64'(fp_s_adr_o), 64'hA000_0001);
    m_cyc_i = 4'b1000;
    m_stb_i = 4'b1000;
    #1;
    check("fp_drop_cyc", 64'(fp_s_cyc_o), 64'h0);
    step;
    check("fp_g3_adr", 64'(fp_s_adr_o), 64'hA000_0003);
    check("fp_g3_ack", 64'(fp_m_ack_o), 64'h8);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    s_ack_i = 1'b0;
    step;

    // Watchdog: slave silent, error in the fourth stalled cycle.
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    step;
    check("to_c1_stb", 64'(rr_s_stb_o), 64'h1);
    check("to_c1_err", 64'(rr_m_err_o), 64'h0);
    step;
    step;
    check("to_c3_err", 64'(rr_m_err_o), 64'h0);
    step;
    check("to_c4_err", 64'(rr_m_err_o), 64'h1);
    check("to_c4_stb", 64'(rr_s_stb_o), 64'h0);
    check("to_c4_ack", 64'(rr_m_ack_o), 64'h0);
    check("to_c4_fp_err", 64'(fp_m_err_o), 64'h1);
    step;
    check("to_after_err", 64'(rr_m_err_o), 64'h0);
    check("to_after_stb", 64'(rr_s_stb_o), 64'h1);

    // Ack arriving in the final watchdog cycle wins over the timeout.
    step;
    step;
    step;
    s_ack_i = 1'b1;
    #1;
    check("to_race_ack", 64'(rr_m_ack_o), 64'h1);
    check("to_race_err", 64'(rr_m_err_o), 64'h0);
    check("to_race_stb", 64'(rr_s_stb_o), 64'h1);
    step;
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    s_ack_i = 1'b0;
    step;

    // Bus hold requested during a master 0 burst.
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    s_ack_i = 1'b1;
    step;
    bus_hold = 1'b1;
    m_cyc_i  = 4'b0011;
    m_stb_i  = 4'b0011;
    #1;
    check("hold_g0_adr", 64'(rr_s_adr_o), 64'hA000_0000);
    check("hold_ack_early", 64'(rr_bus_hold_ack), 64'h0);
    step;
    check("hold_g0_kept", 64'(rr_s_adr_o), 64'hA000_0000);
    check("hold_g0_mack", 64'(rr_m_ack_o), 64'h1);
    m_cyc_i = 4'b0010;
    m_stb_i = 4'b0010;
    #1;
    check("hold_rel_cyc", 64'(rr_s_cyc_o), 64'h0);
    step;
    check("hold_ack_set", 64'(rr_bus_hold_ack), 64'h1);
    check("hold_s_cyc", 64'(rr_s_cyc_o), 64'h0);
    check("hold_m_ack", 64'(rr_m_ack_o), 64'h0);
    step;
    check("hold_ack_stay", 64'(rr_bus_hold_ack), 64'h1);
    bus_hold = 1'b0;
    #1;
    check("hold_ack_reg", 64'(rr_bus_hold_ack), 64'h1);
    step;
    check("hold_ack_drop", 64'(rr_bus_hold_ack), 64'h0);
    check("hold_idle_cyc", 64'(rr_s_cyc_o), 64'h0);
    step;
    check("hold_g1_adr", 64'(rr_s_adr_o), 64'hA000_0001);
    check("hold_g1_cyc", 64'(rr_s_cyc_o), 64'h1);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    s_ack_i = 1'b0;
    step;

    // Reset asserted mid-transaction.
    m_cyc_i = 4'b0100;
    m_stb_i = 4'b0100;
    step;
    check("rst_mid_stb_pre", 64'(rr_s_stb_o), 64'h1);
    check("rst_mid_adr_pre", 64'(rr_s_adr_o), 64'hA000_0002);
    #1;
    rst_ni  = 1'b0;
    s_ack_i = 1'b1;
    #1;
    check("rst_mid_cyc", 64'({rr_s_cyc_o, fp_s_cyc_o}), 64'h0);
    check("rst_mid_stb", 64'({rr_s_stb_o, fp_s_stb_o}), 64'h0);
    check("rst_mid_ack", 64'({rr_m_ack_o, fp_m_ack_o}), 64'h0);
    check("rst_mid_err", 64'({rr_m_err_o, fp_m_err_o}), 64'h0);
    step;
    check("rst_mid_hold", 64'({rr_s_cyc_o, rr_m_ack_o}), 64'h0);
    rst_ni = 1'b1;
    #1;
    check("rst_rel_cyc", 64'(rr_s_cyc_o), 64'h0);
    step;
    check("rst_rel_adr", 64'(rr_s_adr_o), 64'hA000_0002);
    check("rst_rel_ack", 64'(rr_m_ack_o), 64'h4);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    s_ack_i = 1'b0;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arb_mux.md
WB_ARB_MUX -- requirements
Module: wb_arb_mux

Interface
REQ-001 SHALL: MASTERS, default 4, number of Wishbone B3 masters (1..16).
REQ-002 SHALL: DATA_WIDTH, default 32, data width in bits, multiple of 8; SEL_WIDTH = DATA_WIDTH/8 (local).
REQ-003 SHALL: ADDR_WIDTH, default 32, address width in bits.
REQ-004 SHALL: ARB_MODE, default 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 SHALL: TIMEOUT, default 256, watchdog cycles without slave response; 0 disables the watchdog.
REQ-006 SHALL: one clock; reset is asynchronous and active-low.
REQ-007 SHALL: clk_i  in  1  clock, all state on rising edge.
REQ-008 SHALL: rst_ni  in  1  asynchronous active-low reset.
REQ-009 SHALL: m_adr_i/m_dat_i/m_sel_i  in  ADDR_WIDTH/DATA_WIDTH/SEL_WIDTH *MASTERS  flattened master request fields, master m at slice m.
REQ-010 SHALL: m_cyc_i, m_stb_i, m_we_i  in  MASTERS  per-master control; m_cti_i in 3*MASTERS; m_bte_i in 2*MASTERS.
REQ-011 SHALL: m_dat_o out DATA_WIDTH*MASTERS; m_ack_o, m_err_o, m_rty_o out MASTERS  per-master responses.
REQ-012 SHALL: s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cti_o[2:0], s_bte_o[1:0]  out  slave request.
REQ-013 SHALL: s_dat_i in DATA_WIDTH; s_ack_i, s_err_i, s_rty_i in 1  slave response.
REQ-014 SHALL: bus_hold in 1, request to park the bus; bus_hold_ack out 1, registered, bus parked.

Function
REQ-015 SHALL: FSM states IDLE, GRANTED, HOLD; grant held in register gnt_q (one-hot in GRANTED, zero otherwise).
REQ-016 SHALL: arbitration point = IDLE, or GRANTED with m_cyc_i[gnt_q] low; decision loaded into gnt_q at next edge (1-cycle grant latency).
REQ-017 SHALL: at an arbitration point, bus_hold=1 -> HOLD, bus_hold_ack=1 next cycle, requests ignored.
REQ-018 SHALL: otherwise any m_cyc_i high -> GRANTED with winner; none -> IDLE.
REQ-019 SHALL: round-robin: search starts at index last_grant+1, wrapping MASTERS-1 -> 0; last_grant updated on every new grant.
REQ-020 SHALL: fixed priority: lowest-index requesting master wins; last_grant ignored.
REQ-021 SHALL: grant never changes while m_cyc_i[gnt_q] is high (no preemption, bus_hold included).
REQ-022 SHALL: HOLD -> IDLE on the edge after bus_hold falls; bus_hold_ack drops in the same edge.
REQ-023 SHALL: slave request fields mux combinationally from gnt_q; gnt_q zero -> all s_* outputs 0 (no X).
REQ-024 SHALL: m_dat_o broadcasts s_dat_i to every slice; m_ack/err/rty_o[i] = gnt_q[i] & s_* response, except REQ-026.
REQ-025 SHALL: watchdog counter (clog2(TIMEOUT+1) bits) increments each cycle GRANTED & s_stb_o & no s_ack/err/rty; clears on any response, on s_stb_o low, or on grant change.
REQ-026 SHALL: counter == TIMEOUT-1 with no response -> that cycle m_err_o[gnt_q]=1, s_stb_o forced 0, m_ack_o/m_rty_o masked; counter clears next edge.
REQ-027 SHALL: simultaneous slave response and timeout -> slave response wins, no timeout error.
REQ-028 SHALL: MASTERS=1 -> arbitration trivially grants master 0, same latency.

Reset
REQ-029 SHALL: rst_ni low asynchronously forces IDLE, gnt_q=0, last_grant=MASTERS-1 (master 0 first), counter 0, bus_hold_ack 0; all s_* and m_ack/err/rty outputs 0.
REQ-030 SHALL: reset mid-transaction aborts it without generating ack/err to any master; first arbitration follows reset release edge.

Verification
REQ-031 SHALL: RR, masters 0,2 hold m_cyc_i high, each releases after 1 ack -> grants 0,2,0,2; grant 1 cycle after request.
REQ-032 SHALL: ARB_MODE=1, masters 1,3 request continuously with 1-cycle transactions -> master 1 always granted; master 3 only after 1 drops cyc.
REQ-033 SHALL: TIMEOUT=4, slave never responds -> m_err_o[gnt]=1 in 4th stalled cycle, s_stb_o=0 that cycle, counter 0 after.
REQ-034 SHALL: bus_hold=1 during master 0 burst -> grant held to cyc release; then bus_hold_ack=1, s_cyc_o=0 while master 1 waits; bus_hold low -> master 1 granted 2 cycles later.
REQ-035 SHALL: rst_ni low while granted with stb high -> s_cyc_o/s_stb_o=0 immediately, no m_ack_o/m_err_o pulse.
REQ-036 SHALL: s_ack_i in same cycle counter hits TIMEOUT-1 -> m_ack_o=1, m_err_o=0.
